// File: rtl/sram_arbiter.sv
// Two-requester arbiter/sequencer for a single-port synchronous SRAM: IDLE -> ACCESS -> RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin contention handling; otherwise requester 0 has fixed priority.
module sram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_cs,
  output logic              sram_we,
  output logic              sram_rd,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // One extra bit so DEPTH = 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic              win;
  logic              lat_we;
  logic              bad;

  logic              any_req;
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last;
`endif

  always_comb begin
    any_req = req0 | req1;
`ifdef ARB_ROUND_ROBIN_EN
    pick = (req0 & req1) ? ~last : req1;
`else
    pick = ~req0;
`endif
    sel_we    = pick ? we1    : we0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
    in_range  = {1'b0, sel_addr} < LIMIT;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      win       <= 1'b0;
      lat_we    <= 1'b0;
      bad       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last      <= 1'b1;
`endif
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
      sram_addr <= '0;
      sram_cs   <= 1'b0;
      sram_we   <= 1'b0;
      sram_rd   <= 1'b0;
      sram_din  <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            win    <= pick;
            lat_we <= sel_we;
            bad    <= ~in_range;
            busy   <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last   <= pick;
`endif
            if (in_range) begin
              state     <= ACCESS;
              sram_cs   <= 1'b1;
              sram_addr <= sel_addr;
              sram_we   <= sel_we;
              sram_rd   <= ~sel_we;
              sram_din  <= sel_we ? sel_wdata : '0;
            end else begin
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          state   <= RESP;
          sram_cs <= 1'b0;
          sram_we <= 1'b0;
          sram_rd <= 1'b0;
        end
        RESP: begin
          // Ack is issued on leaving RESP so a read captures the SRAM's registered dout.
          state <= IDLE;
          busy  <= 1'b0;
          if (win) begin
            ack1 <= 1'b1;
            err1 <= bad;
            if (bad)          rdata1 <= '0;
            else if (!lat_we) rdata1 <= sram_dout;
          end else begin
            ack0 <= 1'b1;
            err0 <= bad;
            if (bad)          rdata0 <= '0;
            else if (!lat_we) rdata0 <= sram_dout;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 8-word SRAM; follows ARB_ROUND_ROBIN_EN.
module tb_sram_arbiter;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, err0, err1, busy;
  logic [7:0] rdata0, rdata1, sram_addr, sram_din;
  logic       sram_cs, sram_we, sram_rd;
  logic [7:0] sram_dout = '0;
  logic [7:0] mem [8] = '{default: 8'h00};

  int tests = 0, fails = 0;
  int cs_n = 0, ack0_n = 0, ack1_n = 0, err_n = 0, both_n = 0;
  int grants[$];

  sram_arbiter #(.ADDR_W(8), .DATA_W(8), .DEPTH(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .sram_addr(sram_addr), .sram_cs(sram_cs), .sram_we(sram_we), .sram_rd(sram_rd),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 Clk = ~Clk;

  // SRAM model: write at the closing edge, read data registered one cycle after RD.
  always @(posedge Clk) begin
    if (sram_cs && sram_addr < 8) begin
      if (sram_we) mem[sram_addr[2:0]] <= sram_din;
      if (sram_rd) sram_dout <= mem[sram_addr[2:0]];
    end
  end

  always @(negedge Clk) begin
    if (ack0) grants.push_back(0);
    if (ack1) grants.push_back(1);
    cs_n   += int'(sram_cs);
    ack0_n += int'(ack0);
    ack1_n += int'(ack1);
    err_n  += int'(err0) + int'(err1);
    both_n += int'(sram_we & sram_rd);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int id, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input bit drop, output int lat, output logic e, output logic [7:0] rd);
    int n = 0;
    bit got = 0;
    e = 1'b0;
    rd = '0;
    if (id == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else         begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    while (!got && n < 30) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
      if (id == 0 ? ack0 : ack1) begin
        got = 1;
        e  = (id == 0) ? err0 : err1;
        rd = (id == 0) ? rdata0 : rdata1;
      end
    end
    if (!got) check("ack_timeout", 32'(got), 32'd1);
    lat = got ? n - 1 : -1;
    if (drop) begin
      if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  int lat, base, cs0, a0, a1, e0;
  logic e;
  logic [7:0] rd;
  int exp_order [4];

  initial begin
    // Reset held with a pending request: everything stays at zero.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd1;
    repeat (3) begin
      @(negedge Clk);
      check("rst_flags", 32'({ack0, ack1, err0, err1, busy, sram_cs, sram_we, sram_rd}), 32'd0);
      check("rst_data", {rdata0, rdata1, sram_addr, sram_din}, 32'd0);
    end
    req0 = 1'b0;
    Rst_n = 1'b1;
    @(negedge Clk); #1;
    check("rst_cs_count", 32'(cs_n), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Write then read back through requester 0.
    cs0 = cs_n; a1 = ack1_n; e0 = err_n;
    issue(0, 1'b1, 8'd3, 8'hA5, 1, lat, e, rd);
    check("t2_wr_lat", 32'(lat), 32'd2);
    check("t2_wr_err", 32'(e), 32'd0);
    issue(0, 1'b0, 8'd3, 8'h00, 1, lat, e, rd);
    check("t2_rd_lat", 32'(lat), 32'd2);
    check("t2_rd_data", 32'(rd), 32'hA5);
    #1;
    check("t2_cs_cycles", 32'(cs_n - cs0), 32'd2);
    check("t2_no_ack1", 32'(ack1_n - a1), 32'd0);
    check("t2_no_err", 32'(err_n - e0), 32'd0);

    // Prewrite 3C at address 5 from requester 1 and read it back there.
    issue(1, 1'b1, 8'd5, 8'h3C, 1, lat, e, rd);
    check("pre_wr_lat", 32'(lat), 32'd2);
    issue(1, 1'b0, 8'd5, 8'h00, 1, lat, e, rd);
    check("pre_rd_data", 32'(rd), 32'h3C);

    // Out-of-range read: error after one cycle, no SRAM activity, rdata1 cleared.
    @(negedge Clk); #1;
    cs0 = cs_n;
    issue(1, 1'b0, 8'd8, 8'h00, 1, lat, e, rd);
    check("t3_lat", 32'(lat), 32'd1);
    check("t3_err", 32'(e), 32'd1);
    check("t3_rdata", 32'(rd), 32'h00);
    @(negedge Clk); #1;
    check("t3_no_cs", 32'(cs_n - cs0), 32'd0);
    check("t3_rdata0_held", 32'(rdata0), 32'hA5);
    issue(1, 1'b0, 8'hFF, 8'h00, 1, lat, e, rd);
    check("t3_ff_err", 32'(e), 32'd1);

    // Contention: both requesters keep req high across two writes each.
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 1, 1};
`endif
    @(negedge Clk); #1;
    base = grants.size();
    @(negedge Clk);
    fork
      begin
        int l0; logic x0; logic [7:0] r0;
        issue(0, 1'b1, 8'd0, 8'h11, 0, l0, x0, r0);
        issue(0, 1'b1, 8'd6, 8'h66, 1, l0, x0, r0);
      end
      begin
        int l1; logic x1; logic [7:0] r1;
        issue(1, 1'b1, 8'd1, 8'h22, 0, l1, x1, r1);
        issue(1, 1'b1, 8'd7, 8'h77, 1, l1, x1, r1);
      end
    join
    @(negedge Clk); #1;
    check("t4_grant_count", 32'(grants.size() - base), 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t4_order_%0d", k), 32'(grants[base + k]), 32'(exp_order[k]));
    issue(0, 1'b0, 8'd0, 8'h00, 1, lat, e, rd);
    check("t4_rb0", 32'(rd), 32'h11);
    issue(0, 1'b0, 8'd1, 8'h00, 1, lat, e, rd);
    check("t4_rb1", 32'(rd), 32'h22);
    issue(1, 1'b0, 8'd6, 8'h00, 1, lat, e, rd);
    check("t4_rb6", 32'(rd), 32'h66);
    issue(1, 1'b0, 8'd7, 8'h00, 1, lat, e, rd);
    check("t4_rb7", 32'(rd), 32'h77);

    // Reset asserted mid-ACCESS of a write to address 2.
    @(negedge Clk); #1;
    a0 = ack0_n;
    @(negedge Clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd2; wdata0 = 8'h99;
    @(posedge Clk);
    @(negedge Clk);
    check("t6_cs_up", 32'(sram_cs), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("t6_cs_async", 32'(sram_cs), 32'd0);
    check("t6_busy_async", 32'(busy), 32'd0);
    req0 = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk); #1;
    check("t6_no_ack", 32'(ack0_n - a0), 32'd0);
    check("t6_mem2", 32'(mem[2]), 32'h00);
    issue(0, 1'b0, 8'd5, 8'h00, 1, lat, e, rd);
    check("t6_rd_lat", 32'(lat), 32'd2);
    check("t6_rd_data", 32'(rd), 32'h3C);

    @(negedge Clk); #1;
    check("we_rd_exclusive", 32'(both_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
